// File: rtl/servo_pkg.sv
// Shared definitions for the servo driver blocks.
//   servo_state_e : per-channel ramp state (IDLE / OPENING / CLOSING)
//   DEF_*         : 100 MHz default timing constants and the counter widths
//                   they imply.
package servo_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_OPENING = 2'd1,
    ST_CLOSING = 2'd2
  } servo_state_e;

  localparam int unsigned DEF_N_CH        = 2;
  localparam int unsigned DEF_FRAME_CYC   = 2_000_000;  // 20 ms
  localparam int unsigned DEF_PULSE_MIN   = 100_000;    // 1 ms
  localparam int unsigned DEF_PULSE_SPAN  = 100_000;    // +1 ms at full open
  localparam int unsigned DEF_STEP        = 500;
  localparam int unsigned DEF_IDLE_FRAMES = 50;

  localparam int unsigned DEF_CNT_W = $clog2(DEF_FRAME_CYC);
  localparam int unsigned DEF_POS_W = $clog2(DEF_PULSE_SPAN + 1);

endpackage

// File: rtl/servo_ramp_ctrl_if.sv
// Request/status bundle between the request source and servo_ramp_ctrl.
//   open_req / close_req : level requests, one bit per channel
//   pwm                  : servo pulse outputs
//   at_open / at_closed  : end-of-travel flags
//   moving               : channel is ramping
// master = request source, slave = servo_ramp_ctrl.
interface servo_ramp_ctrl_if #(
  parameter int unsigned N_CH = 2
);
  logic [N_CH-1:0] open_req;
  logic [N_CH-1:0] close_req;
  logic [N_CH-1:0] pwm;
  logic [N_CH-1:0] at_open;
  logic [N_CH-1:0] at_closed;
  logic [N_CH-1:0] moving;

  modport master (
    output open_req, close_req,
    input  pwm, at_open, at_closed, moving
  );

  modport slave (
    input  open_req, close_req,
    output pwm, at_open, at_closed, moving
  );
endinterface

// File: rtl/servo_ramp_chan.sv
// One servo channel: ramp FSM, position and compare registers, PWM
// output and status flags. Position and compare change only on frame_end,
// so a pulse width is never altered mid-frame.
//   clk, rst_n           : clock, async active-low reset
//   frame_end            : last cycle of the shared frame
//   frame_nxt            : frame counter value for the next cycle
//   open_req, close_req  : level requests, sampled on frame_end only
//   pwm                  : registered pulse, high while frame count < cmp
//   at_open, at_closed   : position at full open / closed
//   moving               : state is OPENING or CLOSING
// Optional build macro SERVO_IDLE_OFF_EN: after IDLE_FRAMES request-free
// frames the pulse is suppressed until the next request.
module servo_ramp_chan
  import servo_pkg::*;
#(
  parameter int unsigned FRAME_CYC   = DEF_FRAME_CYC,
  parameter int unsigned PULSE_MIN   = DEF_PULSE_MIN,
  parameter int unsigned PULSE_SPAN  = DEF_PULSE_SPAN,
  parameter int unsigned STEP        = DEF_STEP,
  parameter int unsigned IDLE_FRAMES = DEF_IDLE_FRAMES
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         frame_end,
  input  logic [$clog2(FRAME_CYC)-1:0] frame_nxt,
  input  logic                         open_req,
  input  logic                         close_req,
  output logic                         pwm,
  output logic                         at_open,
  output logic                         at_closed,
  output logic                         moving
);
  localparam int unsigned CW = $clog2(FRAME_CYC);
  localparam int unsigned PW = $clog2(PULSE_SPAN + 1);

  servo_state_e  state, state_nxt;
  logic [PW-1:0] pos, pos_nxt, pos_up, pos_dn;
  logic [PW:0]   up_sum;
  logic [CW-1:0] cmp;
  logic          go_open, go_close, sleep_eff;

  assign go_open  = open_req & ~close_req;
  assign go_close = close_req & ~open_req;

  // One bit wider so the saturating step cannot wrap; last step may be partial.
  assign up_sum = {1'b0, pos} + (PW+1)'(STEP);
  assign pos_up = (up_sum >= (PW+1)'(PULSE_SPAN)) ? PW'(PULSE_SPAN) : up_sum[PW-1:0];
  assign pos_dn = ({1'b0, pos} <= (PW+1)'(STEP)) ? '0 : pos - PW'(STEP);

  // A request that opposes the current ramp, a dropped request, or both
  // requests at once all land in IDLE without stepping; the opposite ramp
  // then starts from IDLE on the following frame.
  always_comb begin
    state_nxt = ST_IDLE;
    pos_nxt   = pos;
    if (go_open && state != ST_CLOSING && pos != PW'(PULSE_SPAN)) begin
      pos_nxt   = pos_up;
      state_nxt = (pos_up == PW'(PULSE_SPAN)) ? ST_IDLE : ST_OPENING;
    end else if (go_close && state != ST_OPENING && pos != '0) begin
      pos_nxt   = pos_dn;
      state_nxt = (pos_dn == '0) ? ST_IDLE : ST_CLOSING;
    end
  end

`ifdef SERVO_IDLE_OFF_EN
  localparam int unsigned IW = $clog2(IDLE_FRAMES + 1);

  logic [IW-1:0] idle_cnt, idle_nxt;

  always_comb begin
    idle_nxt = idle_cnt;
    if (open_req | close_req)
      idle_nxt = '0;
    else if (state_nxt == ST_IDLE && idle_cnt != IW'(IDLE_FRAMES))
      idle_nxt = idle_cnt + IW'(1);
  end

  // Use the post-update count on frame_end so the frame that enters sleep
  // emits no leading sliver of pulse.
  assign sleep_eff = frame_end ? (idle_nxt == IW'(IDLE_FRAMES))
                               : (idle_cnt == IW'(IDLE_FRAMES));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         idle_cnt <= '0;
    else if (frame_end) idle_cnt <= idle_nxt;
  end
`else
  assign sleep_eff = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      pos       <= '0;
      cmp       <= CW'(PULSE_MIN);
      pwm       <= 1'b0;
      at_open   <= 1'b0;
      at_closed <= 1'b1;
      moving    <= 1'b0;
    end else begin
      if (frame_end) begin
        state     <= state_nxt;
        pos       <= pos_nxt;
        cmp       <= CW'(PULSE_MIN) + CW'(pos_nxt);
        at_open   <= (pos_nxt == PW'(PULSE_SPAN));
        at_closed <= (pos_nxt == '0);
        moving    <= (state_nxt != ST_IDLE);
      end
      pwm <= ~sleep_eff & (frame_nxt < cmp);
    end
  end
endmodule

// File: rtl/servo_ramp_ctrl.sv
// N-channel hobby-servo driver with per-channel open/close ramping.
// Holds the shared frame counter and one servo_ramp_chan per channel.
//   clk   : system clock
//   rst_n : asynchronous active-low reset
//   bus   : servo_ramp_ctrl_if.slave (open_req, close_req in;
//           pwm, at_open, at_closed, moving out; N_CH bits each)
// Optional build macro SERVO_IDLE_OFF_EN enables idle pulse suppression
// inside each channel.
module servo_ramp_ctrl
  import servo_pkg::*;
#(
  parameter int unsigned N_CH        = DEF_N_CH,
  parameter int unsigned FRAME_CYC   = DEF_FRAME_CYC,
  parameter int unsigned PULSE_MIN   = DEF_PULSE_MIN,
  parameter int unsigned PULSE_SPAN  = DEF_PULSE_SPAN,
  parameter int unsigned STEP        = DEF_STEP,
  parameter int unsigned IDLE_FRAMES = DEF_IDLE_FRAMES
) (
  input  logic              clk,
  input  logic              rst_n,
  servo_ramp_ctrl_if.slave  bus
);
  localparam int unsigned CW = $clog2(FRAME_CYC);

  logic [CW-1:0]   frame_cnt, frame_nxt;
  logic            frame_end;
  logic [N_CH-1:0] pwm_v, at_open_v, at_closed_v, moving_v;

  assign frame_end = (frame_cnt == CW'(FRAME_CYC - 1));
  assign frame_nxt = frame_end ? '0 : frame_cnt + CW'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) frame_cnt <= '0;
    else        frame_cnt <= frame_nxt;
  end

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    servo_ramp_chan #(
      .FRAME_CYC   (FRAME_CYC),
      .PULSE_MIN   (PULSE_MIN),
      .PULSE_SPAN  (PULSE_SPAN),
      .STEP        (STEP),
      .IDLE_FRAMES (IDLE_FRAMES)
    ) u_chan (
      .clk       (clk),
      .rst_n     (rst_n),
      .frame_end (frame_end),
      .frame_nxt (frame_nxt),
      .open_req  (bus.open_req[g]),
      .close_req (bus.close_req[g]),
      .pwm       (pwm_v[g]),
      .at_open   (at_open_v[g]),
      .at_closed (at_closed_v[g]),
      .moving    (moving_v[g])
    );
  end

  assign bus.pwm       = pwm_v;
  assign bus.at_open   = at_open_v;
  assign bus.at_closed = at_closed_v;
  assign bus.moving    = moving_v;
endmodule

// File: tb/tb_servo_ramp_ctrl.sv
// Directed bench for servo_ramp_ctrl with a 100-cycle frame, 10..30 cycle
// pulses and a step of 8 (position 0, 8, 16, 20).
module tb_servo_ramp_ctrl;
  localparam int unsigned FRAME = 100;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   vectors = 0;
  int   miscompares = 0;
  int   tcnt;

  always #5 clk = ~clk;

  servo_ramp_ctrl_if #(.N_CH(2)) bus ();

  servo_ramp_ctrl #(
    .N_CH        (2),
    .FRAME_CYC   (100),
    .PULSE_MIN   (10),
    .PULSE_SPAN  (20),
    .STEP        (8),
    .IDLE_FRAMES (3)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Bench-side frame position, independent of the DUT.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)              tcnt <= 0;
    else if (tcnt == FRAME-1) tcnt <= 0;
    else                     tcnt <= tcnt + 1;
  end

  task automatic check(input string tag, input int obs, input int exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Waits for the negedge at frame position 0 (bounded).
  task automatic wait_frame_start();
    int n = 0;
    @(negedge clk);
    while (tcnt != 0 && n < 2*FRAME) begin
      @(negedge clk);
      n++;
    end
    if (tcnt != 0) check("frame_sync_timeout", tcnt, 0);
  endtask

  // Runs one frame: requests op/cl held all frame, mop added on positions
  // [ms, me). Returns per-channel pulse width of this frame and the flags
  // seen at its start (state after the previous frame_end).
  task automatic run_frame(input logic [1:0] op, input logic [1:0] cl,
                           input logic [1:0] mop, input int ms, input int me,
                           output int w0, output int w1,
                           output int ao, output int ac, output int mv);
    wait_frame_start();
    ao = int'(bus.at_open);
    ac = int'(bus.at_closed);
    mv = int'(bus.moving);
    w0 = 0;
    w1 = 0;
    for (int c = 0; c < FRAME; c++) begin
      if (c > 0) @(negedge clk);
      bus.open_req  = op | ((c >= ms && c < me) ? mop : 2'b00);
      bus.close_req = cl;
      w0 += int'(bus.pwm[0]);
      w1 += int'(bus.pwm[1]);
    end
  endtask

  initial begin
    int w0, w1, ao, ac, mv;
    bus.open_req  = '0;
    bus.close_req = '0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_pwm", int'(bus.pwm), 0);
    check("rst_at_closed", int'(bus.at_closed), 3);
    check("rst_at_open", int'(bus.at_open), 0);
    check("rst_moving", int'(bus.moving), 0);
    rst_n = 1'b1;

    // 1: idle hold at closed
    run_frame(2'b00, 2'b00, 2'b00, 0, 0, w0, w1, ao, ac, mv);
    check("idle_w0", w0, 10);
    check("idle_w1", w1, 10);
    check("idle_at_closed", ac, 3);
    check("idle_at_open", ao, 0);

    // 2: open ch0 for four frame_ends
    run_frame(2'b01, 2'b00, 2'b00, 0, 0, w0, w1, ao, ac, mv);
    check("open0_w0", w0, 10);
    run_frame(2'b01, 2'b00, 2'b00, 0, 0, w0, w1, ao, ac, mv);
    check("open1_w0", w0, 18);
    check("open1_moving", mv, 1);
    check("open1_at_closed", ac, 2);
    check("open1_w1", w1, 10);
    run_frame(2'b01, 2'b00, 2'b00, 0, 0, w0, w1, ao, ac, mv);
    check("open2_w0", w0, 26);
    check("open2_at_open", ao, 0);
    run_frame(2'b01, 2'b00, 2'b00, 0, 0, w0, w1, ao, ac, mv);
    check("open3_w0", w0, 30);
    check("open3_at_open", ao, 1);
    check("open3_moving", mv, 0);

    // 3: close ch0 from full open
    run_frame(2'b00, 2'b01, 2'b00, 0, 0, w0, w1, ao, ac, mv);
    check("open4_w0", w0, 30);
    run_frame(2'b00, 2'b01, 2'b00, 0, 0, w0, w1, ao, ac, mv);
    check("close1_w0", w0, 22);
    check("close1_moving", mv, 1);
    check("close1_at_open", ao, 0);
    run_frame(2'b00, 2'b01, 2'b00, 0, 0, w0, w1, ao, ac, mv);
    check("close2_w0", w0, 14);
    run_frame(2'b00, 2'b01, 2'b00, 0, 0, w0, w1, ao, ac, mv);
    check("close3_w0", w0, 10);
    check("close3_at_closed", ac, 3);
    check("close3_moving", mv, 0);
    run_frame(2'b00, 2'b00, 2'b00, 0, 0, w0, w1, ao, ac, mv);
    check("close4_w0", w0, 10);

    // 4: both requests on ch1 hold position
    run_frame(2'b10, 2'b10, 2'b00, 0, 0, w0, w1, ao, ac, mv);
    run_frame(2'b10, 2'b10, 2'b00, 0, 0, w0, w1, ao, ac, mv);
    check("both1_w1", w1, 10);
    check("both1_moving", mv, 0);
    run_frame(2'b00, 2'b00, 2'b00, 0, 0, w0, w1, ao, ac, mv);
    check("both2_w1", w1, 10);
    check("both2_moving", mv, 0);

    // 5: open pulses that miss frame_end do nothing
    run_frame(2'b00, 2'b00, 2'b01, 40, 60, w0, w1, ao, ac, mv);
    run_frame(2'b00, 2'b00, 2'b01, 10, 98, w0, w1, ao, ac, mv);
    check("midframe1_w0", w0, 10);
    run_frame(2'b00, 2'b00, 2'b00, 0, 0, w0, w1, ao, ac, mv);
    check("midframe2_w0", w0, 10);
    check("midframe2_at_closed", ac, 3);

    // 6: async reset mid-OPENING at pos 16
    run_frame(2'b01, 2'b00, 2'b00, 0, 0, w0, w1, ao, ac, mv);
    run_frame(2'b01, 2'b00, 2'b00, 0, 0, w0, w1, ao, ac, mv);
    check("pre_rst_w0", w0, 18);
    wait_frame_start();
    repeat (5) @(negedge clk);
    check("pre_rst_pwm", int'(bus.pwm), 3);
    check("pre_rst_moving", int'(bus.moving), 1);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_pwm", int'(bus.pwm), 0);
    check("async_rst_moving", int'(bus.moving), 0);
    check("async_rst_at_closed", int'(bus.at_closed), 3);
    bus.open_req = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    run_frame(2'b00, 2'b00, 2'b00, 0, 0, w0, w1, ao, ac, mv);
    check("post_rst_w0", w0, 10);
    check("post_rst_at_closed", ac, 3);

`ifdef SERVO_IDLE_OFF_EN
    run_frame(2'b00, 2'b00, 2'b00, 0, 0, w0, w1, ao, ac, mv);
    run_frame(2'b00, 2'b00, 2'b00, 0, 0, w0, w1, ao, ac, mv);
    run_frame(2'b01, 2'b00, 2'b00, 0, 0, w0, w1, ao, ac, mv);
    check("sleep_w0", w0, 0);
    check("sleep_w1", w1, 0);
    run_frame(2'b00, 2'b00, 2'b00, 0, 0, w0, w1, ao, ac, mv);
    check("wake_w0", w0, 18);
    check("still_sleep_w1", w1, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
